wb_dest_sel_pipe: RTL and testbench

//   Parametrised write-back destination selector with a registered 2-entry elastic stage.

---
 rtl/wb_dest_sel_pipe.sv | 127 ++++++++++++
 tb/tb_wb_dest_sel_pipe.sv | 131 +++++++++++++
 2 files changed

// File: rtl/wb_dest_sel_pipe.sv
// wb_dest_sel_pipe
//   Write-back destination selector feeding the register-file write port.
//   Each accepted instruction has its GPR destination chosen from
//   {rd, rt, LINK_REG, ALT_REG}. The write enable is dropped when the target
//   is register 0 (if ZERO_SUPP). Results sit in a 2-entry elastic stage
//   (HEAD drives out_*, SKID behind it) with a valid/ready handshake on both
//   sides and a synchronous flush.
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid/in_ready        upstream handshake (in_ready from registered state only)
//   in_rd, in_rt, in_sel     destination candidates and selector
//   in_wen                   instruction writes a GPR
//   flush                    synchronous kill of all held entries
//   out_valid/out_ready      downstream handshake
//   out_addr, out_wen        selected address and qualified write enable
//   out_cnt                  number of held entries (0..2)
module wb_dest_sel_pipe #(
  parameter int            AW        = 5,
  parameter logic [AW-1:0] LINK_REG  = '1,
  parameter logic [AW-1:0] ALT_REG   = '1,
  parameter bit            ZERO_SUPP = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rt,
  input  logic [1:0]    in_sel,
  input  logic          in_wen,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic          out_wen,
  output logic [1:0]    out_cnt
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
  } entry_t;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_TWO   = 2'd2;

  logic [1:0] cnt_q, cnt_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  entry_t     new_ent;
  logic       acc, drn;

  // Destination select; the case is full so every sel value yields a defined address.
  always_comb begin
    new_ent = '0;
    unique case (in_sel)
      2'b00:   new_ent.addr = in_rd;
      2'b01:   new_ent.addr = in_rt;
      2'b10:   new_ent.addr = LINK_REG;
      default: new_ent.addr = ALT_REG;
    endcase
    new_ent.wen = in_wen & ~(ZERO_SUPP & (new_ent.addr == '0));
  end

  assign in_ready  = (cnt_q != CNT_TWO);
  assign out_valid = (cnt_q != CNT_EMPTY);
  assign out_addr  = head_q.addr;
  assign out_wen   = head_q.wen;
  assign out_cnt   = cnt_q;

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      cnt_d  = CNT_EMPTY;
      head_d = '0;
      skid_d = '0;
    end else begin
      unique case (cnt_q)
        CNT_EMPTY: begin
          if (acc) begin
            head_d = new_ent;
            cnt_d  = CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (acc && drn) begin
            head_d = new_ent;
          end else if (acc) begin
            skid_d = new_ent;
            cnt_d  = CNT_TWO;
          end else if (drn) begin
            // Clear HEAD so an empty stage presents addr=0/wen=0.
            head_d = '0;
            cnt_d  = CNT_EMPTY;
          end
        end
        default: begin
          // TWO: in_ready is low, only a drain can happen.
          if (drn) begin
            head_d = skid_q;
            skid_d = '0;
            cnt_d  = CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= CNT_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_wb_dest_sel_pipe.sv
module tb_wb_dest_sel_pipe;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rt;
  logic [1:0]    in_sel;
  logic          in_wen;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic          out_wen;
  logic [1:0]    out_cnt;

  int ncmp = 0;
  int nerr = 0;

  wb_dest_sel_pipe #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rt(in_rt), .in_sel(in_sel), .in_wen(in_wen),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_wen(out_wen), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // valid, cnt, in_ready, addr, wen in one go
  task automatic chk_all(input string tag, input logic v, input logic [1:0] c,
                         input logic r, input logic [AW-1:0] a, input logic w);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".cnt"},   {30'd0, out_cnt},   {30'd0, c});
    chk({tag, ".rdy"},   {31'd0, in_ready},  {31'd0, r});
    chk({tag, ".addr"},  {27'd0, out_addr},  {27'd0, a});
    chk({tag, ".wen"},   {31'd0, out_wen},   {31'd0, w});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rt, input logic w);
    in_valid = v; in_sel = sel; in_rd = rd; in_rt = rt; in_wen = w;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 1'b0);
    #3;
    chk_all("reset", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);
    #9 rst_n = 1'b1;

    // select, one per cycle with a concurrent drain
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 5'd8, 5'd9, 1'b1); tick(); chk_all("sel00", 1'b1, 2'd1, 1'b1, 5'd8, 1'b1);
    drive(1'b1, 2'b01, 5'd8, 5'd9, 1'b1); tick(); chk_all("sel01", 1'b1, 2'd1, 1'b1, 5'd9, 1'b1);
    drive(1'b1, 2'b10, 5'd8, 5'd9, 1'b1); tick(); chk_all("sel10", 1'b1, 2'd1, 1'b1, 5'd31, 1'b1);
    drive(1'b1, 2'b11, 5'd8, 5'd9, 1'b1); tick(); chk_all("sel11", 1'b1, 2'd1, 1'b1, 5'd31, 1'b1);

    // zero suppression and plain wen=0
    drive(1'b1, 2'b00, 5'd0, 5'd9, 1'b1); tick(); chk_all("zsupp", 1'b1, 2'd1, 1'b1, 5'd0, 1'b0);
    drive(1'b1, 2'b01, 5'd8, 5'd5, 1'b0); tick(); chk_all("wen0",  1'b1, 2'd1, 1'b1, 5'd5, 1'b0);
    drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0); tick(); chk_all("drain_empty", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);

    // backpressure: A=3, B=4 fill, C=5 held off
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 5'd3, 5'd0, 1'b1); tick(); chk_all("bp_a", 1'b1, 2'd1, 1'b1, 5'd3, 1'b1);
    drive(1'b1, 2'b00, 5'd4, 5'd0, 1'b1); tick(); chk_all("bp_b", 1'b1, 2'd2, 1'b0, 5'd3, 1'b1);
    drive(1'b1, 2'b00, 5'd5, 5'd0, 1'b1); tick(); chk_all("bp_hold", 1'b1, 2'd2, 1'b0, 5'd3, 1'b1);
    out_ready = 1'b1;
    tick(); chk_all("bp_out_b", 1'b1, 2'd1, 1'b1, 5'd4, 1'b1);
    tick(); chk_all("bp_out_c", 1'b1, 2'd1, 1'b1, 5'd5, 1'b1);
    drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick(); chk_all("bp_done", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);

    // flush from full with an input offered on the flush edge
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 5'd10, 5'd0, 1'b1); tick();
    drive(1'b1, 2'b00, 5'd11, 5'd0, 1'b1); tick(); chk_all("fl_full", 1'b1, 2'd2, 1'b0, 5'd10, 1'b1);
    drive(1'b1, 2'b00, 5'd12, 5'd0, 1'b1); flush = 1'b1;
    tick(); chk_all("flush2", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);
    flush = 1'b0; drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick(); chk_all("flush2_after", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);
    // flush from ONE discards a same-edge accept
    drive(1'b1, 2'b00, 5'd13, 5'd0, 1'b1); tick(); chk_all("fl_one", 1'b1, 2'd1, 1'b1, 5'd13, 1'b1);
    drive(1'b1, 2'b00, 5'd14, 5'd0, 1'b1); flush = 1'b1;
    tick(); chk_all("flush1", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);
    flush = 1'b0; drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick(); chk_all("flush1_after", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);

    // streaming at cnt=1, one entry per cycle
    drive(1'b1, 2'b00, 5'd1, 5'd0, 1'b1); tick(); chk_all("st_prime", 1'b1, 2'd1, 1'b1, 5'd1, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b00, 5'(i + 2), 5'd0, 1'b1);
      tick();
      chk($sformatf("st_addr%0d", i), {27'd0, out_addr}, 32'(i + 2));
      chk($sformatf("st_cnt%0d", i), {30'd0, out_cnt}, 32'd1);
    end
    drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick(); chk_all("st_done", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);

    // async reset mid-stream with the stage full
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 5'd0, 5'd20, 1'b1); tick();
    drive(1'b1, 2'b01, 5'd0, 5'd21, 1'b1); tick(); chk_all("rst_full", 1'b1, 2'd2, 1'b0, 5'd20, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all("rst_async", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);
    drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick(); rst_n = 1'b1;
    tick(); chk_all("rst_after", 1'b0, 2'd0, 1'b1, 5'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
